// File: rtl/spi_flash_xip_if.sv
// AXI4 read/write channel bundle between the fabric and the XIP flash slave.
interface spi_flash_xip_if #(
  parameter int DW  = 128,
  parameter int AW  = 32,
  parameter int IDW = 8
);
  logic [IDW-1:0]  awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast, wvalid, wready;
  logic [IDW-1:0]  bid;
  logic [1:0]      bresp;
  logic            bvalid, bready;
  logic [IDW-1:0]  arid;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid, arready;
  logic [IDW-1:0]  rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast, rvalid, rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );
endinterface

// File: rtl/spi_flash_xip.sv
// AXI4 read-only execute-in-place bridge: AR bursts become SPI READ (0x03) transactions
// on one of four NOR devices; writes are drained and answered with SLVERR.
module spi_flash_xip #(
  parameter int DW      = 128,
  parameter int AW      = 32,
  parameter int IDW     = 8,
  parameter int CLK_DIV = 2,
  parameter int CS_HOLD = 4
) (
  input  logic       spi_flash_aclk,
  input  logic       spi_flash_aresetn,
  spi_flash_xip_if.slave axi,
  output logic [3:0] spi_flash_csen,
  output logic [3:0] spi_flash_csn_o,
  input  logic [3:0] spi_flash_csn_i,
  output logic       spi_flash_sdo_en,
  output logic       spi_flash_sdo_o,
  input  logic       spi_flash_sdo_i,
  output logic       spi_flash_sdi_en,
  output logic       spi_flash_sdi_o,
  input  logic       spi_flash_sdi_i,
  output logic       spi_flash_sck,
  output logic       spi_flash_busy
);
  localparam int OFS = $clog2(DW/8);
  localparam int BW  = $clog2(DW);
  localparam int CW  = $clog2(2*CLK_DIV);
  localparam int GW  = $clog2(CS_HOLD+1);
  localparam logic [CW-1:0] HALF     = CW'(CLK_DIV);
  localparam logic [CW-1:0] CELL_END = CW'(2*CLK_DIV-1);
  localparam logic [7:0]    CMD_READ = 8'h03;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_CMD, S_ADDR, S_DATA, S_STALL, S_GAP} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [7:0]     beat_q, beat_d, len_q, len_d;
  logic [IDW-1:0] id_q, id_d, bid_q, bid_d;
  logic [23:0]    addr_q, addr_d;
  logic [1:0]     dev_q, dev_d;
  logic [DW-1:0]  sr_q, sr_d, rdata_q, rdata_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           rvalid_q, rvalid_d, rlast_q, rlast_d, done_q, done_d;
  logic           wpend_q, wpend_d, bvalid_q, bvalid_d;
  logic           cell_end, rise, adv, rhs, aw_rdy, cs_act;
  logic [4:0]     aidx;

  always_comb begin
    state_d  = state_q;  cnt_d  = cnt_q;  bit_d   = bit_q;   beat_d = beat_q;
    len_d    = len_q;    id_d   = id_q;   addr_d  = addr_q;  dev_d  = dev_q;
    sr_d     = sr_q;     rdata_d = rdata_q; gap_d = gap_q;   done_d = done_q;
    rvalid_d = rvalid_q; rlast_d = rlast_q;
    adv      = 1'b0;
    rhs      = rvalid_q & axi.rready;
    cell_end = (cnt_q == CELL_END);
    rise     = (cnt_q == HALF);
    if (rhs) begin
      rvalid_d = 1'b0;
      rlast_d  = 1'b0;
    end
    case (state_q)
      S_IDLE: if (axi.arvalid) begin
        state_d = S_SETUP;
        id_d    = axi.arid;
        len_d   = axi.arlen;
        addr_d  = {axi.araddr[23:OFS], {OFS{1'b0}}};
        dev_d   = axi.araddr[25:24];
        cnt_d   = '0;
        bit_d   = '0;
        beat_d  = '0;
        done_d  = 1'b0;
      end
      S_SETUP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(CLK_DIV-1)) begin
          cnt_d   = '0;
          state_d = S_CMD;
        end
      end
      S_CMD, S_ADDR: begin
        cnt_d = cell_end ? '0 : cnt_q + 1'b1;
        if (cell_end) begin
          bit_d = bit_q + 1'b1;
          if (state_q == S_CMD && bit_q == BW'(7)) begin
            bit_d   = '0;
            state_d = S_ADDR;
          end
          if (state_q == S_ADDR && bit_q == BW'(23)) begin
            bit_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA, S_STALL: begin
        if (done_q) begin
          if (rhs) begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end else begin
          // The serial clock only runs while the output register can take the next beat.
          adv     = ~(rvalid_q & ~axi.rready);
          state_d = adv ? S_DATA : S_STALL;
          if (adv) begin
            cnt_d = cell_end ? '0 : cnt_q + 1'b1;
            // Stream byte k lands in lane k, each byte arriving MSB first.
            if (rise) sr_d[{bit_q[BW-1:3], ~bit_q[2:0]}] = spi_flash_sdi_i;
            if (cell_end) begin
              bit_d = bit_q + 1'b1;
              if (bit_q == BW'(DW-1)) begin
                rdata_d  = sr_d;
                rvalid_d = 1'b1;
                rlast_d  = (beat_q == len_q);
                if (beat_q == len_q) done_d = 1'b1;
                else                 beat_d = beat_q + 1'b1;
              end
            end
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(CS_HOLD-1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write channel: accept and discard, always reply SLVERR.
  always_comb begin
    wpend_d  = wpend_q;
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    aw_rdy   = ~wpend_q & ~bvalid_q;
    if (axi.awvalid && aw_rdy) begin
      wpend_d = 1'b1;
      bid_d   = axi.awid;
    end
    if (wpend_q && axi.wvalid && axi.wlast) begin
      wpend_d  = 1'b0;
      bvalid_d = 1'b1;
    end
    if (bvalid_q && axi.bready) bvalid_d = 1'b0;
  end

  always_ff @(posedge spi_flash_aclk or negedge spi_flash_aresetn) begin
    if (!spi_flash_aresetn) begin
      state_q  <= S_IDLE; cnt_q   <= '0; bit_q  <= '0; beat_q <= '0;
      len_q    <= '0;     id_q    <= '0; addr_q <= '0; dev_q  <= '0;
      sr_q     <= '0;     rdata_q <= '0; gap_q  <= '0; done_q <= 1'b0;
      rvalid_q <= 1'b0;   rlast_q <= 1'b0;
      wpend_q  <= 1'b0;   bvalid_q <= 1'b0; bid_q <= '0;
    end else begin
      state_q  <= state_d;  cnt_q   <= cnt_d;   bit_q  <= bit_d;   beat_q <= beat_d;
      len_q    <= len_d;    id_q    <= id_d;    addr_q <= addr_d;  dev_q  <= dev_d;
      sr_q     <= sr_d;     rdata_q <= rdata_d; gap_q  <= gap_d;   done_q <= done_d;
      rvalid_q <= rvalid_d; rlast_q <= rlast_d;
      wpend_q  <= wpend_d;  bvalid_q <= bvalid_d; bid_q <= bid_d;
    end
  end

  assign cs_act = (state_q inside {S_SETUP, S_CMD, S_ADDR, S_DATA, S_STALL});
  assign aidx   = 5'd23 - bit_q[4:0];

  always_comb begin
    spi_flash_sdo_o = 1'b0;
    if (state_q == S_CMD)  spi_flash_sdo_o = CMD_READ[~bit_q[2:0]];
    if (state_q == S_ADDR) spi_flash_sdo_o = addr_q[aidx];
  end

  assign spi_flash_csn_o  = cs_act ? ~(4'b0001 << dev_q) : 4'hF;
  assign spi_flash_sck    = (state_q inside {S_CMD, S_ADDR, S_DATA, S_STALL}) && (cnt_q >= HALF);
  assign spi_flash_csen   = 4'hF;
  assign spi_flash_sdo_en = 1'b1;
  assign spi_flash_sdi_en = 1'b0;
  assign spi_flash_sdi_o  = 1'b0;
  assign spi_flash_busy   = (state_q != S_IDLE) | wpend_q | bvalid_q;

  assign axi.arready = (state_q == S_IDLE);
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rlast   = rlast_q;
  assign axi.rid     = id_q;
  assign axi.rresp   = 2'b00;
  assign axi.awready = aw_rdy;
  assign axi.wready  = wpend_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = 2'b10;
  assign axi.bid     = bid_q;

  logic unused_ok;
  assign unused_ok = ^{axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.wdata, axi.wstrb,
                       axi.arsize, axi.arburst, axi.araddr, spi_flash_csn_i, spi_flash_sdo_i};
endmodule

// File: tb/tb_spi_flash_xip.sv
// Directed + randomized bench for spi_flash_xip with a behavioural SPI NOR flash model.
module tb_spi_flash_xip;
  localparam int DW = 32, AW = 32, IDW = 8, CD = 3, CSH = 4, BPB = DW/8;
  localparam int FIRST_LAT = 1 + CD + 2*CD*(32+DW);
  localparam int NEXT_LAT  = 2*CD*DW;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_flash_xip_if #(.DW(DW), .AW(AW), .IDW(IDW)) axi();
  logic [3:0] csen, csn_o;
  logic sdo_en, sdo_o, sdi_en, sdi_o, sck, busy;
  logic sdi_i = 1'b0;

  spi_flash_xip #(.DW(DW), .AW(AW), .IDW(IDW), .CLK_DIV(CD), .CS_HOLD(CSH)) dut (
    .spi_flash_aclk(clk), .spi_flash_aresetn(rst_n), .axi(axi),
    .spi_flash_csen(csen), .spi_flash_csn_o(csn_o), .spi_flash_csn_i(4'hF),
    .spi_flash_sdo_en(sdo_en), .spi_flash_sdo_o(sdo_o), .spi_flash_sdo_i(1'b0),
    .spi_flash_sdi_en(sdi_en), .spi_flash_sdi_o(sdi_o), .spi_flash_sdi_i(sdi_i),
    .spi_flash_sck(sck), .spi_flash_busy(busy));

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Flash contents: a plain arithmetic function of device and byte address.
  int seed = 0;
  bit fixed_pat = 1'b0;
  function automatic logic [7:0] fbyte(input logic [1:0] d, input logic [23:0] a);
    int v;
    if (fixed_pat) return 8'h11 * (8'(a[1:0]) + 8'd1);
    v = int'(a) * 37 + int'(a >> 11) + int'(d) * 89 + seed;
    return v[7:0];
  endfunction

  function automatic logic [DW-1:0] model_beat(input logic [1:0] d, input logic [23:0] fa, input int b);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < BPB; k++) r[8*k +: 8] = fbyte(d, fa + 24'(b*BPB + k));
    return r;
  endfunction

  // SPI NOR model: mode 0, 8-bit command + 24-bit address, then stream bytes MSB first.
  int rises = 0;
  logic sck_prev = 1'b0;
  logic [31:0] hdr = '0;
  logic [1:0] mdev = '0;
  logic [23:0] maddr = '0;
  logic [7:0] cmd_q[$];
  logic [23:0] addr_q[$];
  logic [1:0] dev_q[$];
  always @(sck or csn_o) begin
    if (csn_o == 4'hF) begin
      rises = 0;
      sdi_i = 1'b0;
    end else if (sck && !sck_prev) begin
      if (rises < 32) hdr = {hdr[30:0], sdo_o};
      rises++;
      if (rises == 32) begin
        for (int i = 0; i < 4; i++) if (!csn_o[i]) mdev = 2'(i);
        maddr = hdr[23:0];
        cmd_q.push_back(hdr[31:24]);
        addr_q.push_back(hdr[23:0]);
        dev_q.push_back(mdev);
      end
    end else if (!sck && sck_prev && rises >= 32) begin
      int d;
      logic [7:0] byt;
      d = rises - 32;
      byt = fbyte(mdev, maddr + 24'(d/8));
      sdi_i = byt[7 - d%8];
    end
    sck_prev = sck;
  end

  int hi_run = 0, last_gap = 0;
  always @(posedge clk) begin
    if (csn_o == 4'hF) hi_run++;
    else begin
      if (hi_run > 0) last_gap = hi_run;
      hi_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [7:0] id,
                         input int stall_beat, input int stall_n, input bit chk_phase);
    int n, run, bad, bad2;
    bit seen;
    logic s_prev;
    logic [DW-1:0] expd, held;
    logic [23:0] fa, a;
    logic [7:0] c;
    logic [1:0] dv;
    fa = addr[23:0] & ~24'(BPB-1);
    cmd_q.delete(); addr_q.delete(); dev_q.delete();
    axi.araddr = addr; axi.arlen = len; axi.arid = id;
    axi.arsize = 3'd2; axi.arburst = 2'b01; axi.arvalid = 1'b1;
    n = 0;
    while (!axi.arready && n < 2000) begin tick(); n++; end
    chk("ar_ready", axi.arready, 1);
    tick();
    axi.arvalid = 1'b0;
    chk("ar_ready_drop", axi.arready, 0);
    chk("csn_sel", csn_o, 4'hF ^ (4'b0001 << addr[25:24]));
    for (int b = 0; b <= int'(len); b++) begin
      axi.rready = (b != stall_beat);
      n = 1; bad = 0; seen = 1'b0; run = 0; s_prev = sck;
      while (!axi.rvalid && n < 4000) begin
        tick(); n++;
        if (sck != s_prev) begin
          if (seen && run != CD) bad++;
          if (sck) seen = 1'b1;
          run = 1; s_prev = sck;
        end else run++;
      end
      if (b == 0) begin
        chk("lat_first", n, FIRST_LAT);
        if (chk_phase) begin
          chk("sck_seen", seen, 1);
          chk("sck_phase_len", bad, 0);
        end
      end else chk("lat_next", n, NEXT_LAT);
      expd = model_beat(addr[25:24], fa, b);
      chk("rdata", axi.rdata, expd);
      chk("rlast", axi.rlast, b == int'(len));
      chk("rid", axi.rid, id);
      chk("rresp", axi.rresp, 0);
      if (b == stall_beat) begin
        held = axi.rdata; bad2 = 0;
        for (int i = 0; i < stall_n; i++) begin
          tick();
          if (sck !== 1'b0 || csn_o == 4'hF || axi.rvalid !== 1'b1 || axi.rdata !== held) bad2++;
        end
        chk("stall_hold", bad2, 0);
        axi.rready = 1'b1;
      end
      tick();
    end
    chk("csn_release", csn_o, 4'hF);
    chk("cmd_count", cmd_q.size(), 1);
    if (cmd_q.size() != 0) begin
      c = cmd_q.pop_front(); a = addr_q.pop_front(); dv = dev_q.pop_front();
    end else begin
      c = 'x; a = 'x; dv = 'x;
    end
    chk("mosi_cmd", c, 8'h03);
    chk("mosi_addr", a, fa);
    chk("mosi_dev", dv, addr[25:24]);
  endtask

  task automatic do_write(input logic [7:0] id);
    int bad;
    axi.awid = id; axi.awaddr = $urandom; axi.awlen = 8'd2; axi.awsize = 3'd2;
    axi.awburst = 2'b01; axi.awvalid = 1'b1;
    axi.wvalid = 1'b1; axi.wlast = 1'b1; axi.wdata = $urandom; axi.wstrb = '1;
    chk("aw_ready", axi.awready, 1);
    chk("w_blocked_during_aw", axi.wready, 0);
    tick();
    axi.awvalid = 1'b0;
    chk("aw_ready_drop", axi.awready, 0);
    chk("early_wlast_ignored", axi.bvalid, 0);
    for (int i = 0; i < 3; i++) begin
      axi.wlast = (i == 2); axi.wdata = $urandom;
      chk("w_ready", axi.wready, 1);
      tick();
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b10 || axi.bid !== id || axi.wready !== 1'b0) bad++;
      tick();
    end
    chk("b_held", bad, 0);
    chk("bvalid", axi.bvalid, 1);
    chk("bresp", axi.bresp, 2'b10);
    chk("bid", axi.bid, id);
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    chk("b_cleared", axi.bvalid, 0);
    chk("aw_ready_again", axi.awready, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    int rl, sb;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
    axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0;
    axi.arburst = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;
    repeat (3) tick();
    chk("rst_csn", csn_o, 4'hF);
    chk("rst_sck", sck, 0);
    chk("rst_sdo", sdo_o, 0);
    chk("rst_arready", axi.arready, 1);
    chk("rst_awready", axi.awready, 1);
    chk("rst_rvalid", axi.rvalid, 0);
    chk("rst_wready", axi.wready, 0);
    chk("rst_bvalid", axi.bvalid, 0);
    chk("rst_rlast", axi.rlast, 0);
    chk("rst_rdata", axi.rdata, 0);
    chk("rst_busy", busy, 0);
    chk("csen", csen, 4'hF);
    chk("sdo_en", sdo_en, 1);
    chk("sdi_en", {sdi_en, sdi_o}, 0);
    rst_n = 1'b1;
    tick();

    // Single beat on device 1 with a known byte pattern
    fixed_pat = 1'b1;
    do_read(32'h0100_0010, 8'd0, 8'h5A, -1, 0, 1'b1);
    chk("rdata_fixed", axi.rdata, 32'h4433_2211);
    fixed_pat = 1'b0;

    // Four beats, back-pressure held 20 cycles on beat 1
    seed = int'($urandom);
    do_read(32'h0223_4560, 8'd3, 8'h21, 1, 20, 1'b0);

    // Back-to-back reads: chip select must idle high long enough
    do_read(32'h0300_1000, 8'd0, 8'h31, -1, 0, 1'b0);
    do_read(32'h0000_2000, 8'd1, 8'h32, -1, 0, 1'b0);
    chk("cs_gap_min", last_gap >= CSH, 1);

    // Write with delayed bready alongside a read; AR and AW offered in the same cycle
    seed = int'($urandom);
    fork
      do_read(32'h0140_0100, 8'd1, 8'h41, -1, 0, 1'b0);
      do_write(8'hA7);
    join

    // Flash address wraps inside the device without a new command
    seed = int'($urandom);
    do_read(32'h00FF_FFFC, 8'd1, 8'h51, -1, 0, 1'b0);

    // Reset in the middle of the address phase
    axi.araddr = 32'h0200_0100; axi.arlen = 8'd0; axi.arid = 8'h61; axi.arvalid = 1'b1;
    for (int i = 0; i < 50 && !axi.arready; i++) tick();
    tick();
    axi.arvalid = 1'b0;
    repeat (CD + 2*CD*8 + 2*CD*4) tick();
    chk("busy_in_addr", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_csn", csn_o, 4'hF);
    chk("mid_rst_sck", sck, 0);
    chk("mid_rst_rvalid", axi.rvalid, 0);
    chk("mid_rst_arready", axi.arready, 1);
    chk("mid_rst_no_cmd", cmd_q.size(), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    seed = int'($urandom);
    do_read(32'h0200_0100, 8'd0, 8'h62, -1, 0, 1'b0);

    // Randomized reads
    for (int r = 0; r < 3; r++) begin
      seed = int'($urandom);
      ra = $urandom & 32'h03FF_FFFF;
      rl = int'($urandom_range(0, 2));
      sb = int'($urandom_range(0, rl));
      do_read(ra, 8'(rl), 8'($urandom), sb, int'($urandom_range(1, 6)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
